// File: rtl/fetch_redirect_unit_pkg.sv
// Shared types and defaults for the fetch redirect unit: address type,
// reset PC and the recovery FSM encoding.
package fetch_redirect_unit_pkg;

    localparam int unsigned ADDR_W = 32;

    typedef logic [ADDR_W-1:0] addr_t;

    localparam addr_t RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } fsm_state_e;

endpackage

// File: rtl/fetch_redirect_unit_sat_counter.sv
// Saturating up-counter: increments on inc and sticks at all-ones.
module sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fetch_redirect_unit.sv
// Next-PC selection, EX-stage branch resolution, flush generation,
// predictor update bus and performance counters around the gshare predictor.
module fetch_redirect_unit
    import fetch_redirect_unit_pkg::*;
#(
    parameter addr_t       RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             bp_hit,
    input  logic             bp_prediction,
    input  addr_t            bp_target,
    input  logic             ex_valid,
    input  logic             ex_taken,
    input  addr_t            ex_pc,
    input  addr_t            ex_target,
    input  logic             ex_pred_taken,
    input  addr_t            ex_pred_target,
    output addr_t            pc,
    output logic             if_pred_taken,
    output addr_t            if_pred_target,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             mispredict,
    output logic             upd_valid,
    output logic             upd_taken,
    output addr_t            upd_pc,
    output addr_t            upd_target,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispred_count
);

    fsm_state_e state;
    fsm_state_e state_next;
    addr_t      pc_next;
    addr_t      fix_pc;
    logic       use_pred;

    // State and fetch PC registers; reset discards any pending redirect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    // Resolution, redirect priority and FSM next state.
    always_comb begin
        state_next     = state;
        use_pred       = bp_hit & bp_prediction;
        if_pred_taken  = use_pred;
        if_pred_target = '0;
        upd_valid      = 1'b0;
        upd_taken      = 1'b0;
        upd_pc         = '0;
        upd_target     = '0;
        mispredict     = 1'b0;
        fix_pc         = ex_taken ? ex_target : ex_pc + ADDR_W'(4);
        pc_next        = pc + ADDR_W'(4);

        if (use_pred) begin
            if_pred_target = bp_target;
        end

        // EX holds a squashed bubble while recovering, so its contents are ignored.
        if (ex_valid && (state == RUN)) begin
            upd_valid  = 1'b1;
            upd_taken  = ex_taken;
            upd_pc     = ex_pc;
            upd_target = ex_target;
            mispredict = (ex_taken != ex_pred_taken) ||
                         (ex_taken && (ex_target != ex_pred_target));
        end

        if (mispredict) begin
            pc_next = fix_pc;
        end else if (stall) begin
            pc_next = pc;
        end else if (use_pred) begin
            pc_next = bp_target;
        end

        case (state)
            RUN:     if (mispredict) state_next = RECOVER;
            RECOVER: state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    assign flush_if_id = mispredict;
    assign flush_id_ex = mispredict;

    sat_counter #(.CNT_W(CNT_W)) u_branch_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (upd_valid),
        .count (branch_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_mispred_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (mispredict),
        .count (mispred_count)
    );

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Randomized bench for fetch_redirect_unit against a cycle-level reference model.
module tb_fetch_redirect_unit;

    localparam int unsigned CNT_W    = 4;
    localparam logic [31:0] RST_PC   = 32'h0000_0000;
    localparam int          CNT_MAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             stall, bp_hit, bp_prediction;
    logic [31:0]      bp_target;
    logic             ex_valid, ex_taken, ex_pred_taken;
    logic [31:0]      ex_pc, ex_target, ex_pred_target;
    logic [31:0]      pc, if_pred_target, upd_pc, upd_target;
    logic             if_pred_taken, flush_if_id, flush_id_ex, mispredict;
    logic             upd_valid, upd_taken;
    logic [CNT_W-1:0] branch_count, mispred_count;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_pc;
    bit          m_squash;
    int          m_bc, m_mc;

    fetch_redirect_unit #(.RESET_PC(RST_PC), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .bp_hit         (bp_hit),
        .bp_prediction  (bp_prediction),
        .bp_target      (bp_target),
        .ex_valid       (ex_valid),
        .ex_taken       (ex_taken),
        .ex_pc          (ex_pc),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .pc             (pc),
        .if_pred_taken  (if_pred_taken),
        .if_pred_target (if_pred_target),
        .flush_if_id    (flush_if_id),
        .flush_id_ex    (flush_id_ex),
        .mispredict     (mispredict),
        .upd_valid      (upd_valid),
        .upd_taken      (upd_taken),
        .upd_pc         (upd_pc),
        .upd_target     (upd_target),
        .branch_count   (branch_count),
        .mispred_count  (mispred_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input bit st, input bit hit, input bit pr, input logic [31:0] bt,
                         input bit ev, input bit et, input logic [31:0] epc,
                         input logic [31:0] etg, input bit ept, input logic [31:0] eptg);
        stall = st; bp_hit = hit; bp_prediction = pr; bp_target = bt;
        ex_valid = ev; ex_taken = et; ex_pc = epc; ex_target = etg;
        ex_pred_taken = ept; ex_pred_target = eptg;
    endtask

    // Called at posedge+1 after drive(): checks this cycle, advances model, checks next edge.
    task automatic step();
        bit          pred, resolved, wrong;
        logic [31:0] nxt;
        #1;
        pred     = bp_hit && bp_prediction;
        resolved = ex_valid && !m_squash;
        wrong    = resolved && ((ex_taken != ex_pred_taken) ||
                                (ex_taken && (ex_target != ex_pred_target)));
        check("pc", pc, m_pc);
        check("if_pred_taken", if_pred_taken, pred);
        check("if_pred_target", if_pred_target, pred ? bp_target : 32'h0);
        check("mispredict", mispredict, wrong);
        check("flush_if_id", flush_if_id, wrong);
        check("flush_id_ex", flush_id_ex, wrong);
        check("upd_valid", upd_valid, resolved);
        if (resolved) begin
            check("upd_taken", upd_taken, ex_taken);
            check("upd_pc", upd_pc, ex_pc);
            check("upd_target", upd_target, ex_target);
        end
        if (wrong)          nxt = ex_taken ? ex_target : ex_pc + 32'd4;
        else if (stall)     nxt = m_pc;
        else if (pred)      nxt = bp_target;
        else                nxt = m_pc + 32'd4;
        m_pc     = nxt;
        m_squash = wrong;
        if (resolved && m_bc < CNT_MAX) m_bc++;
        if (wrong && m_mc < CNT_MAX)    m_mc++;
        @(posedge clk);
        #1;
        check("pc_next", pc, m_pc);
        check("branch_count", branch_count, m_bc);
        check("mispred_count", mispred_count, m_mc);
    endtask

    task automatic idle();
        drive(0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    endtask

    // Async reset between edges: effect must be visible before the next clock.
    task automatic async_reset();
        idle();
        reset = 1'b1;
        #2;
        check("rst_pc", pc, RST_PC);
        check("rst_bc", branch_count, 0);
        check("rst_mc", mispred_count, 0);
        check("rst_flush", {flush_if_id, flush_id_ex, mispredict, upd_valid}, 4'h0);
        m_pc = RST_PC; m_squash = 0; m_bc = 0; m_mc = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        a = $urandom;
        if ($urandom_range(0, 9) == 0) a = 32'hFFFF_FFFC;
        return {a[31:2], 2'b00};
    endfunction

    initial begin
        idle();
        reset = 1'b1;
        m_pc = RST_PC; m_squash = 0; m_bc = 0; m_mc = 0;
        @(posedge clk); @(posedge clk);
        #1;
        reset = 1'b0;
        check("init_pc", pc, RST_PC);
        check("init_counts", {branch_count, mispred_count}, 0);

        // Sequential fetch and stall
        repeat (3) begin idle(); step(); end
        check("seq_pc_c", pc, 32'hC);
        drive(1, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 32'h0); step();
        check("stall_hold", pc, 32'hC);
        idle(); step();
        // Predicted taken at 0x10
        drive(0, 1, 1, 32'h80, 0, 0, 32'h0, 32'h0, 0, 32'h0); step();
        check("pred_redirect", pc, 32'h80);
        // Mispredicted not-taken under stall
        drive(1, 1, 1, 32'h500, 1, 1, 32'h20, 32'h100, 0, 32'h0); step();
        check("misp_nt_pc", pc, 32'h100);
        check("misp_nt_cnt", mispred_count, 1);
        drive(0, 0, 0, 32'h0, 1, 1, 32'h24, 32'h900, 0, 32'h0); step();
        // Mispredicted taken, then ignored EX in recovery
        drive(0, 0, 0, 32'h0, 1, 0, 32'h40, 32'h0, 1, 32'h60); step();
        check("misp_t_pc", pc, 32'h44);
        drive(0, 0, 0, 32'h0, 1, 1, 32'h44, 32'h700, 0, 32'h0); step();
        // Wrong target
        drive(0, 0, 0, 32'h0, 1, 1, 32'h50, 32'h200, 1, 32'h204); step();
        check("wrong_tgt_pc", pc, 32'h200);
        idle(); step();
        // Correct prediction
        drive(0, 0, 0, 32'h0, 1, 1, 32'h60, 32'h300, 1, 32'h300); step();
        // PC wrap at the top of the address space
        drive(0, 1, 1, 32'hFFFF_FFFC, 0, 0, 32'h0, 32'h0, 0, 32'h0); step();
        idle(); step();
        check("wrap_pc", pc, 32'h0);
        drive(0, 0, 0, 32'h0, 1, 0, 32'hFFFF_FFFC, 32'h0, 1, 32'h8); step();
        check("fix_wrap_pc", pc, 32'h0);

        // Reset mid-run
        async_reset();

        // Randomized traffic with occasional mid-run resets
        for (int i = 0; i < 600; i++) begin
            logic [31:0] t, pt;
            bit et, ept;
            t   = rnd_addr();
            et  = $urandom_range(0, 1) == 1;
            ept = ($urandom_range(0, 3) == 0) ? !et : et;
            pt  = ($urandom_range(0, 3) == 0) ? rnd_addr() : t;
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0,
                  rnd_addr(), $urandom_range(0, 1) == 1, et, rnd_addr(), t, ept, pt);
            step();
            if ($urandom_range(0, 149) == 0) async_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
